mem_write_checker: RTL

//   Synthesizable end-of-program checker on the processor's data-memory write port (MemWrite/DataAdr/WriteData).

---
 rtl/mem_write_checker_if.sv | 10 +
 rtl/mem_write_checker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_write_checker_if.sv
// Data-memory store port as seen by the end-of-program checker.
// The core (or a bench) drives it as master; the checker only observes.
interface mem_write_checker_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface

// File: rtl/mem_write_checker.sv
// End-of-program checker: watches stores for EXP_ADDR and latches PASS/FAIL/TIMEOUT
// together with cycle/write counts and the last store, all held until reset.
module mem_write_checker #(
  parameter logic [31:0] EXP_ADDR   = 32'd100,
  parameter logic [31:0] EXP_DATA   = 32'd7,
  parameter int unsigned TIMEOUT    = 40,
  parameter int unsigned MAX_WRITES = 16,
  localparam int unsigned CW        = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  mem_write_checker_if.slave   st,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [CW-1:0]        cycle_count,
  output logic [7:0]           write_count,
  output logic [31:0]          last_addr,
  output logic [31:0]          last_data
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_PASS = 3'd2;
  localparam logic [2:0] ST_FAIL = 3'd3;
  localparam logic [2:0] ST_TOUT = 3'd4;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_DATA  = 2'b01;
  localparam logic [1:0] FC_WRITE = 2'b10;
  localparam logic [1:0] FC_TOUT  = 2'b11;

  localparam logic [CW-1:0] TO_W  = CW'(TIMEOUT);
  localparam logic [7:0]    MW_W  = 8'(MAX_WRITES);

  logic [2:0]    st_q,   st_d;
  logic [CW-1:0] cyc_q,  cyc_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [7:0]    oth_q,  oth_d;
  logic [31:0]   la_q,   la_d;
  logic [31:0]   ld_q,   ld_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [1:0]    fc_q,   fc_d;

  // Address/data compares are qualified by the strobe so undriven bus
  // values while MemWrite=0 can never leak into state.
  logic store, hit, hit_ok, other;

  always_comb begin
    store  = (st.MemWrite == 1'b1);
    hit    = store && (st.DataAdr == EXP_ADDR);
    hit_ok = hit && (st.WriteData == EXP_DATA);
    other  = store && !hit;
  end

  always_comb begin
    st_d   = st_q;
    cyc_d  = cyc_q;
    wcnt_d = wcnt_q;
    oth_d  = oth_q;
    la_d   = la_q;
    ld_d   = ld_q;
    done_d = done_q;
    pass_d = pass_q;
    fc_d   = fc_q;

    case (st_q)
      ST_IDLE: begin
        // The arming edge only starts the run; nothing is sampled on it.
        if (enable) st_d = ST_RUN;
      end

      ST_RUN: begin
        if (enable) begin
          if (cyc_q != TO_W) cyc_d = cyc_q + CW'(1);

          if (store) begin
            if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
            la_d = st.DataAdr;
            ld_d = st.WriteData;
          end
          if (other && oth_q != 8'hFF) oth_d = oth_q + 8'd1;

          // Verdict priority: pass > wrong data > too many writes > timeout.
          if (hit_ok) begin
            st_d   = ST_PASS;
            done_d = 1'b1;
            pass_d = 1'b1;
            fc_d   = FC_NONE;
          end else if (hit) begin
            st_d   = ST_FAIL;
            done_d = 1'b1;
            fc_d   = FC_DATA;
          end else if (other && oth_d == MW_W) begin
            st_d   = ST_FAIL;
            done_d = 1'b1;
            fc_d   = FC_WRITE;
          end else if (cyc_d == TO_W) begin
            st_d   = ST_TOUT;
            done_d = 1'b1;
            fc_d   = FC_TOUT;
          end
        end
      end

      ST_PASS, ST_FAIL, ST_TOUT: ;

      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_IDLE;
      cyc_q  <= '0;
      wcnt_q <= '0;
      oth_q  <= '0;
      la_q   <= '0;
      ld_q   <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fc_q   <= FC_NONE;
    end else begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      wcnt_q <= wcnt_d;
      oth_q  <= oth_d;
      la_q   <= la_d;
      ld_q   <= ld_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fc_q   <= fc_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fc_q;
  assign cycle_count = cyc_q;
  assign write_count = wcnt_q;
  assign last_addr   = la_q;
  assign last_data   = ld_q;

endmodule
